// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register interface.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_DEV_ADDR = 4'd1,
      ST_DEV_ACK  = 4'd2,
      ST_REG_ADDR = 4'd3,
      ST_REG_ACK  = 4'd4,
      ST_WR_DATA  = 4'd5,
      ST_WR_ACK   = 4'd6,
      ST_RD_LOAD  = 4'd7,
      ST_RD_DATA  = 4'd8,
      ST_RD_ACK   = 4'd9,
      ST_IGNORE   = 4'd10
   } i2c_state_e;

   localparam logic I2C_ACK   = 1'b0;
   localparam logic I2C_NACK  = 1'b1;
   localparam int   BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_line_sync.sv
// One I2C line: synchronizer, optional 3-sample majority filter
// (I2C_GLITCH_FILTER_EN), and rise/fall detect on the cleaned level.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_in,
   output logic line,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   line_v;
   logic                   prev_q;

   // Idle I2C lines sit high, so reset the chain high to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
   end

`ifdef I2C_GLITCH_FILTER_EN
   logic [2:0] samp_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) samp_q <= '1;
      else        samp_q <= {samp_q[1:0], sync_q[SYNC_STAGES-1]};
   end

   assign line_v = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                   (samp_q[1] & samp_q[2]);
`else
   assign line_v = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev_q <= 1'b1;
      else        prev_q <= line_v;
   end

   assign line = line_v;
   assign rise = line_v & ~prev_q;
   assign fall = ~line_v & prev_q;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target turning bus transfers into register strobes on xtal_clk.
// Define I2C_GLITCH_FILTER_EN to add a majority glitch filter on SCL/SDA.
module i2c_target_regif
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h50,
   parameter int         SYNC_STAGES = 2,
   parameter int         IDLE_CNT_W  = 8
) (
   input  logic       xtal_clk,
   input  logic       por_rst_n,
   input  logic       hif_scl,
   input  logic       hif_sda_in,
   output logic       hif_sda_oe,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       hif_idle_out,
   output logic [3:0] dbg_state
);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk(xtal_clk), .rst_n(por_rst_n), .line_in(hif_scl),
      .line(scl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk(xtal_clk), .rst_n(por_rst_n), .line_in(hif_sda_in),
      .line(sda), .rise(sda_rise), .fall(sda_fall)
   );

   i2c_state_e           state_q, state_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
   logic [7:0]           addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 rw_q, rw_d;
   logic                 mack_q, mack_d;
   logic                 oe_q, oe_d;
   logic                 we_q, we_d;
   logic                 re_c;
   logic [IDLE_CNT_W-1:0] idle_cnt_q;

   logic       start_det, stop_det, last_bit, bus_edge;
   logic [7:0] byte_in;

   assign start_det = sda_fall & scl;
   assign stop_det  = sda_rise & scl;
   assign last_bit  = (bit_cnt_q == BIT_CNT_W'(7));
   assign byte_in   = {shift_q[6:0], sda};
   assign bus_edge  = scl_rise | scl_fall | sda_rise | sda_fall;

   always_ff @(posedge xtal_clk or negedge por_rst_n) begin
      if (!por_rst_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rw_q      <= 1'b0;
         mack_q    <= I2C_NACK;
         oe_q      <= 1'b0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rw_q      <= rw_d;
         mack_q    <= mack_d;
         oe_q      <= oe_d;
         we_q      <= we_d;
      end
   end

   // In the ACK states oe_q doubles as the phase flag: the first SCL fall
   // starts driving ACK, the second one ends the ACK slot.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rw_d      = rw_q;
      mack_d    = mack_q;
      oe_d      = oe_q;
      we_d      = 1'b0;
      re_c      = 1'b0;

      if (we_q) addr_d = addr_q + 8'd1;

      if (start_det) begin
         state_d   = ST_DEV_ADDR;
         bit_cnt_d = '0;
         oe_d      = 1'b0;
      end else if (stop_det) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
      end else begin
         case (state_q)
            ST_DEV_ADDR: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               if (last_bit) begin
                  if (shift_q[6:0] == DEV_ADDR) begin
                     rw_d    = sda;
                     state_d = ST_DEV_ACK;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            ST_DEV_ACK: if (scl_fall) begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else if (rw_q) begin
                  re_c    = 1'b1;
                  state_d = ST_RD_LOAD;
               end else begin
                  oe_d      = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = ST_REG_ADDR;
               end
            end
            ST_REG_ADDR: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               if (last_bit) begin
                  addr_d  = byte_in;
                  state_d = ST_REG_ACK;
               end
            end
            ST_REG_ACK, ST_WR_ACK: if (scl_fall) begin
               if (!oe_q) begin
                  oe_d = 1'b1;
               end else begin
                  oe_d      = 1'b0;
                  bit_cnt_d = '0;
                  state_d   = ST_WR_DATA;
               end
            end
            ST_WR_DATA: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               if (last_bit) begin
                  wdata_d = byte_in;
                  we_d    = 1'b1;
                  state_d = ST_WR_ACK;
               end
            end
            ST_RD_LOAD: begin
               shift_d   = reg_rdata;
               addr_d    = addr_q + 8'd1;
               oe_d      = ~reg_rdata[7];
               bit_cnt_d = '0;
               state_d   = ST_RD_DATA;
            end
            ST_RD_DATA: if (scl_fall) begin
               bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
               if (last_bit) begin
                  oe_d    = 1'b0;
                  state_d = ST_RD_ACK;
               end else begin
                  shift_d = {shift_q[6:0], 1'b0};
                  oe_d    = ~shift_q[6];
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) mack_d = sda;
               if (scl_fall) begin
                  if (mack_q == I2C_ACK) begin
                     re_c    = 1'b1;
                     state_d = ST_RD_LOAD;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge xtal_clk or negedge por_rst_n) begin
      if (!por_rst_n)                           idle_cnt_q <= '1;
      else if (bus_edge || state_q != ST_IDLE)  idle_cnt_q <= '0;
      else if (!(&idle_cnt_q))                  idle_cnt_q <= idle_cnt_q + IDLE_CNT_W'(1);
   end

   // Strobe handshake: reg_we is a one-cycle strobe with reg_addr/reg_wdata
   // valid in that same cycle; reg_re is a one-cycle request and reg_rdata
   // is sampled in the cycle after it. Neither strobe can be back-pressured.
   assign hif_sda_oe   = oe_q;
   assign reg_addr     = addr_q;
   assign reg_wdata    = wdata_q;
   assign reg_we       = we_q;
   assign reg_re       = re_c;
   assign hif_idle_out = &idle_cnt_q;
   assign dbg_state    = state_q;

endmodule
